// File: rtl/clock_time_ctrl_if.sv
// Panel-side signal bundle of the clock controller: buttons and format switch in,
// time fields, tick, mode and digit blank mask out.
interface clock_time_ctrl_if;
    logic       btn_mode;
    logic       btn_inc;
    logic       switch;
    logic       tick;
    logic [1:0] mode;
    logic [4:0] hour;
    logic [4:0] disp_hour;
    logic       pm;
    logic [5:0] minute;
    logic [5:0] second;
    logic [5:0] blank;

    modport master (
        output btn_mode, btn_inc, switch,
        input  tick, mode, hour, disp_hour, pm, minute, second, blank
    );

    modport slave (
        input  btn_mode, btn_inc, switch,
        output tick, mode, hour, disp_hour, pm, minute, second, blank
    );
endinterface

// File: rtl/clock_time_ctrl.sv
// HH:MM:SS timekeeper: 1 Hz prescaler, button-driven set mode, 12/24 h display hour and blink mask.
// Define CLOCK_TIME_CTRL_DEBOUNCE_EN to add a stable-level debounce on both buttons.
module clock_time_ctrl #(
    parameter int CLK_HZ          = 50_000_000,
    parameter int BLINK_HZ        = 2,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic             clk,
    input  logic             reset,
    clock_time_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } mode_e;

    localparam int                 PRE_W       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRE_W-1:0]   PRE_MAX     = PRE_W'(CLK_HZ - 1);
    localparam int                 HALF_PERIOD = CLK_HZ / (2 * BLINK_HZ);
    localparam int                 BLK_W       = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [BLK_W-1:0]   BLK_MAX     = BLK_W'(HALF_PERIOD - 1);

    if (CLK_HZ < 2 || BLINK_HZ < 1 || HALF_PERIOD < 1 || DEBOUNCE_CYCLES < 1) begin : g_param_check
        $error("clock_time_ctrl: need CLK_HZ >= 2*BLINK_HZ, BLINK_HZ >= 1, DEBOUNCE_CYCLES >= 1");
    end

    // Button path: bit 1 = mode, bit 0 = inc.
    logic [1:0] btn_meta;
    logic [1:0] btn_sync;
    logic [1:0] btn_level;
    logic [1:0] btn_prev;
    logic [1:0] btn_pulse;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            btn_meta <= {bus.btn_mode, bus.btn_inc};
            btn_sync <= btn_meta;
        end
    end

`ifdef CLOCK_TIME_CTRL_DEBOUNCE_EN
    localparam int              DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0][DB_W-1:0] db_cnt;

    // The accepted level follows the synchronized input only after it has differed for DEBOUNCE_CYCLES edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_cnt    <= '0;
            btn_level <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (btn_sync[i] == btn_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_MAX) begin
                    db_cnt[i]    <= '0;
                    btn_level[i] <= btn_sync[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end
`else
    assign btn_level = btn_sync;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_prev <= '0;
        end else begin
            btn_prev <= btn_level;
        end
    end

    assign btn_pulse = btn_level & ~btn_prev;

    logic mode_pulse;
    logic inc_pulse;
    assign mode_pulse = btn_pulse[1];
    assign inc_pulse  = btn_pulse[0];

    // Timekeeping and set-mode state.
    mode_e            mode_q;
    mode_e            mode_next;
    logic [PRE_W-1:0] pre_cnt;
    logic [BLK_W-1:0] blk_cnt;
    logic             phase;
    logic [4:0]       hour_q;
    logic [5:0]       minute_q;
    logic [5:0]       second_q;
    logic             tick_c;
    logic             enter_set;
    logic             inc_accept;

    // NOTE: every variable written in always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        mode_next = RUN;
        case (mode_q)
            RUN:      mode_next = SET_HOUR;
            SET_HOUR: mode_next = SET_MIN;
            SET_MIN:  mode_next = SET_SEC;
            SET_SEC:  mode_next = RUN;
            default:  mode_next = RUN;
        endcase
    end

    assign tick_c     = (mode_q == RUN) && (pre_cnt == PRE_MAX);
    assign enter_set  = mode_pulse && (mode_next != RUN);
    // A mode pulse swallows a coincident inc pulse.
    assign inc_accept = inc_pulse && !mode_pulse && (mode_q != RUN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q   <= RUN;
            pre_cnt  <= '0;
            blk_cnt  <= '0;
            phase    <= 1'b1;
            hour_q   <= '0;
            minute_q <= '0;
            second_q <= '0;
        end else begin
            if (mode_q != RUN || mode_pulse || pre_cnt == PRE_MAX) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + PRE_W'(1);
            end

            if (enter_set || inc_accept) begin
                blk_cnt <= '0;
                phase   <= 1'b1;
            end else if (blk_cnt == BLK_MAX) begin
                blk_cnt <= '0;
                phase   <= ~phase;
            end else begin
                blk_cnt <= blk_cnt + BLK_W'(1);
            end

            if (mode_pulse) begin
                mode_q <= mode_next;
            end

            // Ticks only happen in RUN and accepted incs only in SET states, so the two never collide.
            if (tick_c) begin
                if (second_q == 6'd59) begin
                    second_q <= '0;
                    if (minute_q == 6'd59) begin
                        minute_q <= '0;
                        hour_q   <= (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                    end else begin
                        minute_q <= minute_q + 6'd1;
                    end
                end else begin
                    second_q <= second_q + 6'd1;
                end
            end else if (inc_accept) begin
                case (mode_q)
                    SET_HOUR: hour_q   <= (hour_q == 5'd23)   ? 5'd0 : hour_q + 5'd1;
                    SET_MIN:  minute_q <= (minute_q == 6'd59) ? 6'd0 : minute_q + 6'd1;
                    SET_SEC:  second_q <= '0;
                    default:  ;
                endcase
            end
        end
    end

    // Display hour: 12 h format shows 0 and 12 as 12.
    logic [4:0] disp_hour_c;
    always_comb begin
        disp_hour_c = hour_q;
        if (bus.switch) begin
            if (hour_q == 5'd0) begin
                disp_hour_c = 5'd12;
            end else if (hour_q > 5'd12) begin
                disp_hour_c = hour_q - 5'd12;
            end
        end
    end

    logic [5:0] blank_c;
    always_comb begin
        blank_c = '0;
        case (mode_q)
            SET_HOUR: blank_c[5:4] = {2{~phase}};
            SET_MIN:  blank_c[3:2] = {2{~phase}};
            SET_SEC:  blank_c[1:0] = {2{~phase}};
            default:  blank_c      = '0;
        endcase
    end

    assign bus.tick      = tick_c;
    assign bus.mode      = mode_q;
    assign bus.hour      = hour_q;
    assign bus.disp_hour = disp_hour_c;
    assign bus.pm        = (hour_q >= 5'd12);
    assign bus.minute    = minute_q;
    assign bus.second    = second_q;
    assign bus.blank     = blank_c;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Self-checking bench for clock_time_ctrl: display table, hand-written corner sequences and
// randomized button traffic checked every cycle against a seconds-of-day reference model.
module tb_clock_time_ctrl;
    localparam int CLK_HZ          = 10;
    localparam int BLINK_HZ        = 1;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int HALF            = CLK_HZ / (2 * BLINK_HZ);
`ifdef CLOCK_TIME_CTRL_DEBOUNCE_EN
    localparam int LAT  = 3 + DEBOUNCE_CYCLES;
    localparam int HOLD = 8;
`else
    localparam int LAT  = 3;
    localparam int HOLD = 20;
`endif

    logic clk = 1'b0;
    logic reset;

    clock_time_ctrl_if bus ();

    clock_time_ctrl #(
        .CLK_HZ         (CLK_HZ),
        .BLINK_HZ       (BLINK_HZ),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int errors;
    int checks;
    int cyc;

    // Reference model: time as seconds of day, mode index, cycle ages for prescaler and blink.
    int m_secs;
    int m_mode;
    int m_run_age;
    int m_blink_age;
    int q_mode[$];
    int q_inc[$];

    typedef struct {
        int incs;
        bit sw;
        int exp_hour;
        int exp_disp;
        int exp_pm;
    } disp_vec_t;

    disp_vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at edge %0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        cyc         = 0;
        m_secs      = 0;
        m_mode      = 0;
        m_run_age   = 0;
        m_blink_age = 0;
        q_mode.delete();
        q_inc.delete();
    endtask

    task automatic model_edge();
        bit mev;
        bit iev;
        int h;
        int mi;
        int s;
        mev = 1'b0;
        iev = 1'b0;
        if (q_mode.size() > 0 && q_mode[0] == cyc) begin
            mev = 1'b1;
            void'(q_mode.pop_front());
        end
        if (q_inc.size() > 0 && q_inc[0] == cyc) begin
            iev = 1'b1;
            void'(q_inc.pop_front());
        end
        if (m_mode == 0 && (m_run_age % CLK_HZ) == CLK_HZ - 1)
            m_secs = (m_secs + 1) % 86400;
        if (m_mode == 0)
            m_run_age++;
        if (mev) begin
            m_mode    = (m_mode + 1) % 4;
            m_run_age = 0;
            if (m_mode != 0) m_blink_age = 0;
            else             m_blink_age++;
        end else if (iev && m_mode != 0) begin
            h  = m_secs / 3600;
            mi = (m_secs / 60) % 60;
            s  = m_secs % 60;
            if (m_mode == 1) h  = (h + 1) % 24;
            if (m_mode == 2) mi = (mi + 1) % 60;
            if (m_mode == 3) s  = 0;
            m_secs      = h * 3600 + mi * 60 + s;
            m_blink_age = 0;
        end else begin
            m_blink_age++;
        end
    endtask

    task automatic compare_all();
        int h;
        int dh;
        bit vis;
        logic [5:0] bl;
        h   = m_secs / 3600;
        dh  = bus.switch ? (((h % 12) == 0) ? 12 : h % 12) : h;
        vis = ((m_blink_age / HALF) % 2) == 0;
        bl  = '0;
        if (!vis) begin
            case (m_mode)
                1:       bl = 6'b110000;
                2:       bl = 6'b001100;
                3:       bl = 6'b000011;
                default: bl = 6'b000000;
            endcase
        end
        check("tick",   bus.tick, (m_mode == 0 && (m_run_age % CLK_HZ) == CLK_HZ - 1) ? 1 : 0);
        check("mode",   bus.mode, m_mode);
        check("hour",   bus.hour, h);
        check("minute", bus.minute, (m_secs / 60) % 60);
        check("second", bus.second, m_secs % 60);
        check("disp",   bus.disp_hour, dh);
        check("pm",     bus.pm, (h >= 12) ? 1 : 0);
        check("blank",  bus.blank, bl);
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        compare_all();
    endtask

    // Reset asserted away from any edge; outputs must clear before the next edge.
    task automatic do_reset();
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        bus.switch   = 1'b0;
        reset        = 1'b0;
        #1;
        check("rst_tick",   bus.tick, 0);
        check("rst_mode",   bus.mode, 0);
        check("rst_hour",   bus.hour, 0);
        check("rst_minute", bus.minute, 0);
        check("rst_second", bus.second, 0);
        check("rst_disp",   bus.disp_hour, 0);
        check("rst_pm",     bus.pm, 0);
        check("rst_blank",  bus.blank, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic press(input bit do_mode, input bit do_inc, input int hold, input int gap);
        if (do_mode) begin
            bus.btn_mode = 1'b1;
            q_mode.push_back(cyc + LAT);
        end
        if (do_inc) begin
            bus.btn_inc = 1'b1;
            q_inc.push_back(cyc + LAT);
        end
        repeat (hold) step();
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        repeat (gap) step();
    endtask

    task automatic tap(input bit do_mode, input bit do_inc);
        press(do_mode, do_inc, 6, 6);
    endtask

    int tick_cnt;
    int t_edge;
    bit found;
    int op;

    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        bus.switch   = 1'b0;
        reset        = 1'b1;

        vecs[0] = '{0,  1'b1, 0,  12, 0};
        vecs[1] = '{0,  1'b0, 0,  0,  0};
        vecs[2] = '{1,  1'b1, 1,  1,  0};
        vecs[3] = '{11, 1'b1, 12, 12, 1};
        vecs[4] = '{1,  1'b1, 13, 1,  1};
        vecs[5] = '{0,  1'b0, 13, 13, 1};
        vecs[6] = '{9,  1'b1, 22, 10, 1};
        vecs[7] = '{1,  1'b1, 23, 11, 1};
        vecs[8] = '{1,  1'b1, 0,  12, 0};
        vecs[9] = '{1,  1'b0, 1,  1,  0};

        #1;
        do_reset();

        // Free run: ticks during cycles 10/20/30.
        tick_cnt = 0;
        for (int i = 0; i < 35; i++) begin
            step();
            if (bus.tick === 1'b1) begin
                tick_cnt++;
                check("tick_phase", cyc % CLK_HZ, CLK_HZ - 1);
            end
        end
        check("tick_count_35", tick_cnt, 3);
        check("second_after_35", bus.second, 3);
        #2;
        do_reset();

        // Display-hour table, walked in SET_HOUR.
        tap(1'b1, 1'b0);
        for (int v = 0; v < 10; v++) begin
            for (int k = 0; k < vecs[v].incs; k++) tap(1'b0, 1'b1);
            bus.switch = vecs[v].sw;
            #1;
            check("tbl_hour", bus.hour, vecs[v].exp_hour);
            check("tbl_disp", bus.disp_hour, vecs[v].exp_disp);
            check("tbl_pm",   bus.pm, vecs[v].exp_pm);
        end
        bus.switch = 1'b0;

        // Hour 22 -> three presses -> 1, blink restarts visible after the last press.
        for (int k = 0; k < 21; k++) tap(1'b0, 1'b1);
        check("hour_22", bus.hour, 22);
        tap(1'b0, 1'b1);
        tap(1'b0, 1'b1);
        bus.btn_inc = 1'b1;
        q_inc.push_back(cyc + LAT);
        repeat (LAT) step();
        bus.btn_inc = 1'b0;
        for (int i = 0; i < 12; i++) begin
            check("blink_hour", bus.blank[5:4], ((i / HALF) % 2 == 1) ? 2'b11 : 2'b00);
            step();
        end
        check("wrap_hour", bus.hour, 1);
        check("wrap_minute", bus.minute, 0);

        // Simultaneous mode and inc in SET_MIN: mode wins.
        tap(1'b1, 1'b0);
        for (int k = 0; k < 5; k++) tap(1'b0, 1'b1);
        tap(1'b1, 1'b1);
        check("simul_mode", bus.mode, 3);
        check("simul_minute", bus.minute, 5);

        // Back to RUN, then into SET_MIN again for the press-length sequences.
        tap(1'b1, 1'b0);
        tap(1'b1, 1'b0);
        tap(1'b1, 1'b0);
        check("setmin_mode", bus.mode, 2);
`ifdef CLOCK_TIME_CTRL_DEBOUNCE_EN
        bus.btn_inc = 1'b1;
        repeat (3) step();
        bus.btn_inc = 1'b0;
        repeat (12) step();
        check("glitch_minute", bus.minute, 5);
`endif
        bus.btn_inc = 1'b1;
        q_inc.push_back(cyc + LAT);
        repeat (LAT - 1) step();
        check("press_before", bus.minute, 5);
        step();
        check("press_after", bus.minute, 6);
        repeat (HOLD - LAT) step();
        bus.btn_inc = 1'b0;
        repeat (10) step();
        check("press_once", bus.minute, 6);
        #2;
        do_reset();

        // Set 23:59:00, return to RUN, run to 23:59:59 and across midnight.
        tap(1'b1, 1'b0);
        for (int k = 0; k < 23; k++) tap(1'b0, 1'b1);
        tap(1'b1, 1'b0);
        for (int k = 0; k < 59; k++) tap(1'b0, 1'b1);
        tap(1'b1, 1'b0);
        t_edge = cyc + LAT;
        tap(1'b1, 1'b0);
        found = 1'b0;
        for (int k = 0; k < 3 * CLK_HZ && !found; k++) begin
            step();
            if (bus.second == 6'd1) found = 1'b1;
        end
        check("first_tick_found", found, 1);
        check("first_tick_edge", cyc, t_edge + CLK_HZ);
        for (int k = 0; k < 1000 && m_secs != 86399; k++) step();
        check("pre_mid_hour", bus.hour, 23);
        check("pre_mid_minute", bus.minute, 59);
        check("pre_mid_second", bus.second, 59);
        check("pre_mid_pm", bus.pm, 1);
        found = 1'b0;
        for (int k = 0; k < 2 * CLK_HZ && !found; k++) begin
            if (bus.tick === 1'b1) found = 1'b1;
            else step();
        end
        check("mid_tick_found", found, 1);
        step();
        check("mid_hour", bus.hour, 0);
        check("mid_minute", bus.minute, 0);
        check("mid_second", bus.second, 0);
        check("mid_pm", bus.pm, 0);

        // Randomized button traffic against the model.
        for (int i = 0; i < 150; i++) begin
            op = $urandom_range(0, 9);
            if ($urandom_range(0, 3) == 0) bus.switch = 1'($urandom_range(0, 1));
            if (op < 3)       press(1'b1, 1'b0, $urandom_range(6, 10), $urandom_range(6, 10));
            else if (op < 8)  press(1'b0, 1'b1, $urandom_range(6, 10), $urandom_range(6, 10));
            else if (op == 8) press(1'b1, 1'b1, $urandom_range(6, 10), $urandom_range(6, 10));
            else              repeat ($urandom_range(1, 25)) step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
